// File: rtl/fetch_pkg.sv
// Shared constants and counter encodings for the fetch/branch-prediction slice.
package fetch_pkg;

  localparam int              XLEN     = 32;
  localparam int              ENTRIES  = 16;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_INIT = CTR_WNT;

  // Saturating 2-bit step; never wraps past SNT or ST.
  function automatic ctr_e ctr_step(input ctr_e c, input logic taken);
    ctr_e r;
    r = c;
    unique case (c)
      CTR_SNT: r = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: r = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  r = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  r = taken ? CTR_ST  : CTR_WT;
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fetch_predict_unit_if.sv
// Fetch-side and EX-resolve signal bundle for the fetch/predict unit.
interface fetch_predict_unit_if #(parameter int XLEN = 32);

  logic            stall;
  logic [XLEN-1:0] pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            ID_Flush;
  logic            EX_Flush;
  logic            mispredict;

  modport master (
    input  stall, ex_valid, ex_pc, ex_branch, ex_jump, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pc, pred_taken, pred_target, ID_Flush, EX_Flush, mispredict
  );

  modport slave (
    output stall, ex_valid, ex_pc, ex_branch, ex_jump, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pc, pred_taken, pred_target, ID_Flush, EX_Flush, mispredict
  );

endinterface

// File: rtl/btb_table.sv
// Direct-mapped BTB with 2-bit counters: combinational read port, registered write port.
module btb_table
  import fetch_pkg::*;
#(
  parameter int   ENTRIES  = 16,
  parameter int   XLEN     = 32,
  parameter ctr_e CTR_INIT = CTR_WNT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_taken,
  output logic [XLEN-1:0] rd_target,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic            wr_taken,
  input  logic [XLEN-1:0] wr_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic            valid_q [ENTRIES];
  logic            valid_d [ENTRIES];
  logic [TAG_W-1:0] tag_q  [ENTRIES];
  logic [TAG_W-1:0] tag_d  [ENTRIES];
  logic [XLEN-1:0] tgt_q   [ENTRIES];
  logic [XLEN-1:0] tgt_d   [ENTRIES];
  ctr_e            ctr_q   [ENTRIES];
  ctr_e            ctr_d   [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit;

  assign rd_idx = rd_pc[IDX_W+1:2];
  assign rd_tag = rd_pc[XLEN-1:IDX_W+2];
  assign wr_idx = wr_pc[IDX_W+1:2];
  assign wr_tag = wr_pc[XLEN-1:IDX_W+2];

  always_comb begin
    rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_taken  = rd_hit && ctr_q[rd_idx][1];
    rd_target = tgt_q[rd_idx];
    wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  end

  // Taken outcomes (re)allocate; a fresh allocation starts weakly taken.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (wr_en) begin
      if (wr_taken) begin
        valid_d[wr_idx] = 1'b1;
        tag_d[wr_idx]   = wr_tag;
        tgt_d[wr_idx]   = wr_target;
        ctr_d[wr_idx]   = wr_hit ? ctr_step(ctr_q[wr_idx], 1'b1) : CTR_WT;
      end else if (wr_hit) begin
        ctr_d[wr_idx]   = ctr_step(ctr_q[wr_idx], 1'b0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_INIT;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
    end
  end

endmodule

// File: rtl/fetch_predict_unit.sv
// IF-stage PC register with BTB-based next-PC prediction and EX-driven redirect/flush.
module fetch_predict_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter int              ENTRIES  = fetch_pkg::ENTRIES,
  parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter ctr_e            CTR_INIT = fetch_pkg::CTR_INIT
) (
  input logic                  clk,
  input logic                  rst_n,
  fetch_predict_unit_if.master bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            btb_taken;
  logic [XLEN-1:0] btb_target;
  logic [XLEN-1:0] pred_target;
  logic            is_ctrl, act_taken, mispredict;
  logic [XLEN-1:0] act_tgt, fall_pc;

  btb_table #(
    .ENTRIES  (ENTRIES),
    .XLEN     (XLEN),
    .CTR_INIT (CTR_INIT)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_pc     (pc_q),
    .rd_taken  (btb_taken),
    .rd_target (btb_target),
    .wr_en     (bus.ex_valid && is_ctrl),
    .wr_pc     (bus.ex_pc),
    .wr_taken  (act_taken),
    .wr_target (act_tgt)
  );

  // Jumps are always taken; bit 0 of every resolved target is forced low.
  always_comb begin
    is_ctrl     = bus.ex_branch | bus.ex_jump;
    act_taken   = bus.ex_jump | (bus.ex_branch & bus.ex_taken);
    act_tgt     = {bus.ex_target[XLEN-1:1], 1'b0};
    fall_pc     = bus.ex_pc + XLEN'(4);
    pred_target = btb_taken ? btb_target : pc_q + XLEN'(4);
    mispredict  = bus.ex_valid && is_ctrl &&
                  ((act_taken != bus.ex_pred_taken) ||
                   (act_taken && (act_tgt != bus.ex_pred_target)));
  end

  always_comb begin
    pc_d = pred_target;
    if (mispredict) begin
      pc_d = act_taken ? act_tgt : fall_pc;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pred_taken  = btb_taken;
  assign bus.pred_target = pred_target;
  assign bus.ID_Flush    = mispredict;
  assign bus.EX_Flush    = mispredict;
  assign bus.mispredict  = mispredict;

endmodule
